// File: rtl/polara_loopback_checker_pkg.sv
// Shared definitions for the Polara loopback generator/checker pair:
// OpenPiton header field layout, the loopback message type and default expectations.
package polara_loopback_checker_pkg;

    localparam int CHIPID_LSB   = 50;
    localparam int CHIPID_W     = 14;
    localparam int XPOS_LSB     = 42;
    localparam int XPOS_W       = 8;
    localparam int YPOS_LSB     = 34;
    localparam int YPOS_W       = 8;
    localparam int FBITS_LSB    = 30;
    localparam int FBITS_W      = 4;
    localparam int LEN_LSB      = 22;
    localparam int LEN_W        = 8;
    localparam int MSG_TYPE_LSB = 14;
    localparam int MSG_TYPE_W   = 8;
    localparam int MSHR_LSB     = 6;
    localparam int MSHR_W       = 8;

    localparam logic [7:0]  MSG_TYPE_INV_FWD = 8'd18;
    localparam logic [13:0] DEF_CHIPID       = 14'b10000000000000;
    localparam logic [3:0]  DEF_FBITS        = 4'b0010;

    typedef enum logic {
        ST_HDR  = 1'b0,
        ST_BODY = 1'b1
    } state_e;

endpackage

// File: rtl/polara_noc_hdr_check.sv
// Combinational compare of one OpenPiton header flit against the expected loopback message.
module polara_noc_hdr_check
    import polara_loopback_checker_pkg::*;
#(
    parameter logic [13:0] EXP_CHIPID   = DEF_CHIPID,
    parameter logic [3:0]  EXP_FBITS    = DEF_FBITS,
    parameter logic [7:0]  EXP_MSG_TYPE = MSG_TYPE_INV_FWD,
    parameter logic [7:0]  MAX_PAYLOAD  = 8'd8
) (
    input  logic [63:0] flit_i,
    output logic        bad_o,
    output logic [7:0]  len_o
);

    // Position, MSHR and reserved fields are not part of the check.
    logic unused_fields;
    assign unused_fields = ^{flit_i[XPOS_LSB +: XPOS_W], flit_i[YPOS_LSB +: YPOS_W],
                             flit_i[MSHR_LSB +: MSHR_W], flit_i[5:0]};

    assign len_o = flit_i[LEN_LSB +: LEN_W];
    assign bad_o = (flit_i[CHIPID_LSB +: CHIPID_W]     != EXP_CHIPID)
                 | (flit_i[FBITS_LSB +: FBITS_W]       != EXP_FBITS)
                 | (flit_i[MSG_TYPE_LSB +: MSG_TYPE_W] != EXP_MSG_TYPE)
                 | (len_o > MAX_PAYLOAD);

endmodule

// File: rtl/polara_loopback_checker.sv
// Receive-side loopback checker: drains the three returned NoC channels, parses packets on the
// switch-selected channel, and keeps good/bad packet counters plus the last bad header.
module polara_loopback_checker
    import polara_loopback_checker_pkg::*;
#(
    parameter logic [13:0] EXP_CHIPID   = DEF_CHIPID,
    parameter logic [3:0]  EXP_FBITS    = DEF_FBITS,
    parameter logic [7:0]  EXP_MSG_TYPE = MSG_TYPE_INV_FWD,
    parameter logic [7:0]  MAX_PAYLOAD  = 8'd8
) (
    input  logic        chipset_clk,
    input  logic        chipset_rst_n,
    input  logic [1:0]  sw_debounced,
    input  logic        clear,
    input  logic [63:0] intf_chipset_data_noc1,
    input  logic [63:0] intf_chipset_data_noc2,
    input  logic [63:0] intf_chipset_data_noc3,
    input  logic        intf_chipset_val_noc1,
    input  logic        intf_chipset_val_noc2,
    input  logic        intf_chipset_val_noc3,
    output logic        intf_chipset_rdy_noc1,
    output logic        intf_chipset_rdy_noc2,
    output logic        intf_chipset_rdy_noc3,
    output logic        pkt_done,
    output logic [15:0] pkt_count,
    output logic [7:0]  err_count,
    output logic        err_sticky,
    output logic [63:0] last_err_hdr,
    output state_e      dbg_state_o
);

    // Handshake: a flit moves on a rising edge where val && rdy; rdy is the same
    // registered signal on all three channels, so unselected channels simply drain.
    logic        rdy_q;
    state_e      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [7:0]  rem_q, rem_d;
    logic        bad_q, bad_d;
    logic [63:0] hdr_q, hdr_d;
    logic        fin_q, fin_d;
    logic        fin_bad_q, fin_bad_d;
    logic [63:0] fin_hdr_q, fin_hdr_d;
    logic [1:0]  sel_eff;
    logic [63:0] flit;
    logic        val;
    logic        acc;
    logic        hdr_bad;
    logic [7:0]  hdr_len;

    polara_noc_hdr_check #(
        .EXP_CHIPID  (EXP_CHIPID),
        .EXP_FBITS   (EXP_FBITS),
        .EXP_MSG_TYPE(EXP_MSG_TYPE),
        .MAX_PAYLOAD (MAX_PAYLOAD)
    ) u_hdr_check (
        .flit_i(flit),
        .bad_o (hdr_bad),
        .len_o (hdr_len)
    );

    always_comb begin
        sel_eff = (state_q == ST_HDR) ? sw_debounced : sel_q;
        flit    = 64'd0;
        val     = 1'b0;
        case (sel_eff)
            2'd1:    begin flit = intf_chipset_data_noc1; val = intf_chipset_val_noc1; end
            2'd2:    begin flit = intf_chipset_data_noc2; val = intf_chipset_val_noc2; end
            2'd3:    begin flit = intf_chipset_data_noc3; val = intf_chipset_val_noc3; end
            default: begin flit = 64'd0; val = 1'b0; end
        endcase
        acc = val & rdy_q;
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rem_d     = rem_q;
        bad_d     = bad_q;
        hdr_d     = hdr_q;
        fin_d     = 1'b0;
        fin_bad_d = bad_q;
        fin_hdr_d = hdr_q;
        case (state_q)
            ST_HDR: begin
                if (acc) begin
                    sel_d = sw_debounced;
                    hdr_d = flit;
                    bad_d = hdr_bad;
                    rem_d = hdr_len;
                    if (hdr_len == 8'd0) begin
                        fin_d     = 1'b1;
                        fin_bad_d = hdr_bad;
                        fin_hdr_d = flit;
                    end else begin
                        state_d = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (acc) begin
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        fin_d   = 1'b1;
                        state_d = ST_HDR;
                    end
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
        if (!chipset_rst_n) begin
            rdy_q     <= 1'b0;
            state_q   <= ST_HDR;
            sel_q     <= 2'd0;
            rem_q     <= 8'd0;
            bad_q     <= 1'b0;
            hdr_q     <= 64'd0;
            fin_q     <= 1'b0;
            fin_bad_q <= 1'b0;
            fin_hdr_q <= 64'd0;
        end else begin
            rdy_q     <= 1'b1;
            state_q   <= state_d;
            sel_q     <= sel_d;
            rem_q     <= rem_d;
            bad_q     <= bad_d;
            hdr_q     <= hdr_d;
            fin_q     <= fin_d;
            fin_bad_q <= fin_bad_d;
            fin_hdr_q <= fin_hdr_d;
        end
    end

    // Status lands one edge after the final flit; clear overrides a coincident finish.
    always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
        if (!chipset_rst_n) begin
            pkt_done     <= 1'b0;
            pkt_count    <= 16'd0;
            err_count    <= 8'd0;
            err_sticky   <= 1'b0;
            last_err_hdr <= 64'd0;
        end else begin
            pkt_done <= fin_q;
            if (fin_q && fin_bad_q) begin
                last_err_hdr <= fin_hdr_q;
            end
            if (clear) begin
                pkt_count  <= 16'd0;
                err_count  <= 8'd0;
                err_sticky <= 1'b0;
            end else if (fin_q) begin
                if (fin_bad_q) begin
                    err_sticky <= 1'b1;
                    if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                end else if (pkt_count != 16'hFFFF) begin
                    pkt_count <= pkt_count + 16'd1;
                end
            end
        end
    end

    assign intf_chipset_rdy_noc1 = rdy_q;
    assign intf_chipset_rdy_noc2 = rdy_q;
    assign intf_chipset_rdy_noc3 = rdy_q;
    assign dbg_state_o           = state_q;

endmodule

// File: tb/tb_polara_loopback_checker.sv
// Directed bench for polara_loopback_checker with hand-built headers and expected counts.
module tb_polara_loopback_checker;

    logic        clk;
    logic        rst_n;
    logic [1:0]  sw;
    logic        clear;
    logic [63:0] d1, d2, d3;
    logic        v1, v2, v3;
    logic        r1, r2, r3;
    logic        pkt_done;
    logic [15:0] pkt_count;
    logic [7:0]  err_count;
    logic        err_sticky;
    logic [63:0] last_err_hdr;
    logic        dbg_state;

    int n_checks;
    int n_errors;

    polara_loopback_checker dut (
        .chipset_clk           (clk),
        .chipset_rst_n         (rst_n),
        .sw_debounced          (sw),
        .clear                 (clear),
        .intf_chipset_data_noc1(d1),
        .intf_chipset_data_noc2(d2),
        .intf_chipset_data_noc3(d3),
        .intf_chipset_val_noc1 (v1),
        .intf_chipset_val_noc2 (v2),
        .intf_chipset_val_noc3 (v3),
        .intf_chipset_rdy_noc1 (r1),
        .intf_chipset_rdy_noc2 (r2),
        .intf_chipset_rdy_noc3 (r3),
        .pkt_done              (pkt_done),
        .pkt_count             (pkt_count),
        .err_count             (err_count),
        .err_sticky            (err_sticky),
        .last_err_hdr          (last_err_hdr),
        .dbg_state_o           (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] mk_hdr(input logic [13:0] chipid, input logic [3:0] fbits,
                                           input logic [7:0] len, input logic [7:0] mtype);
        return {chipid, 8'h05, 8'h0a, fbits, len, mtype, 8'h33, 6'h15};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic flit(input int ch, input logic [63:0] d);
        @(negedge clk);
        v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
        case (ch)
            1: begin d1 = d; v1 = 1'b1; end
            2: begin d2 = d; v2 = 1'b1; end
            3: begin d3 = d; v3 = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic idle();
        @(negedge clk);
        v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Called right after the final flit was presented: done must be low until the
    // edge after acceptance, high for exactly one cycle, then low again.
    task automatic finish_pkt(input string tag);
        idle();
        chk({tag, "_done_early"}, pkt_done, 1'b0);
        @(posedge clk); #1;
        chk({tag, "_done"}, pkt_done, 1'b1);
        @(posedge clk); #1;
        chk({tag, "_done_once"}, pkt_done, 1'b0);
    endtask

    logic [63:0] good0, bad_t19, bad_cid, bad_fb, hdr;

    initial begin
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; sw = 2'd0; clear = 1'b0;
        d1 = 64'd0; d2 = 64'd0; d3 = 64'd0;
        v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
        good0   = mk_hdr(14'h2000, 4'd2, 8'd0, 8'd18);
        bad_t19 = mk_hdr(14'h2000, 4'd2, 8'd0, 8'd19);
        bad_cid = mk_hdr(14'h2001, 4'd2, 8'd0, 8'd18);
        bad_fb  = mk_hdr(14'h2000, 4'd3, 8'd0, 8'd18);

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_rdy", {r1, r2, r3}, 3'b000);
        chk("rst_done", pkt_done, 1'b0);
        chk("rst_pkt", pkt_count, 16'd0);
        chk("rst_err", err_count, 8'd0);
        chk("rst_sticky", err_sticky, 1'b0);
        chk("rst_last", last_err_hdr, 64'd0);
        chk("rst_state", dbg_state, 1'b0);
        rst_n = 1'b1;
        #1 chk("rdy_before_edge", {r1, r2, r3}, 3'b000);
        @(posedge clk); #1;
        chk("rdy_after_edge", {r1, r2, r3}, 3'b111);

        // len==0 good header on noc1
        sw = 2'd1;
        flit(1, good0);
        finish_pkt("len0");
        chk("len0_pkt", pkt_count, 16'd1);
        chk("len0_sticky", err_sticky, 1'b0);

        // len=3 on noc2, back-to-back payload
        pulse_clear();
        chk("clr1_pkt", pkt_count, 16'd0);
        sw = 2'd2;
        flit(2, mk_hdr(14'h2000, 4'd2, 8'd3, 8'd18));
        for (int i = 0; i < 3; i++) flit(2, 64'h0123_4567_89ab_cdef + 64'(i));
        finish_pkt("len3");
        chk("len3_pkt", pkt_count, 16'd1);
        chk("len3_state", dbg_state, 1'b0);

        // bad msg_type on noc3, then a good packet
        pulse_clear();
        sw = 2'd3;
        flit(3, bad_t19);
        finish_pkt("t19");
        chk("t19_err", err_count, 8'd1);
        chk("t19_sticky", err_sticky, 1'b1);
        chk("t19_last", last_err_hdr, bad_t19);
        chk("t19_pkt", pkt_count, 16'd0);
        flit(3, good0);
        finish_pkt("after_bad");
        chk("after_bad_pkt", pkt_count, 16'd1);
        chk("after_bad_sticky", err_sticky, 1'b1);
        chk("after_bad_err", err_count, 8'd1);

        // other chipid / fbits mismatches
        pulse_clear();
        sw = 2'd1;
        flit(1, bad_cid);
        flit(1, bad_fb);
        idle();
        repeat (2) @(posedge clk); #1;
        chk("cid_fb_err", err_count, 8'd2);
        chk("cid_fb_last", last_err_hdr, bad_fb);
        chk("cid_fb_pkt", pkt_count, 16'd0);

        // traffic on unselected channels drains without counting
        pulse_clear();
        sw = 2'd1;
        @(negedge clk);
        d2 = good0; v2 = 1'b1; d3 = bad_t19; v3 = 1'b1;
        @(posedge clk); #1;
        chk("drain_rdy23", {r2, r3}, 2'b11);
        repeat (3) @(posedge clk); #1;
        idle();
        repeat (2) @(posedge clk); #1;
        chk("drain_pkt", pkt_count, 16'd0);
        chk("drain_err", err_count, 8'd0);
        chk("drain_done", pkt_done, 1'b0);

        // sel==0: nothing parsed
        sw = 2'd0;
        flit(1, good0);
        flit(2, bad_t19);
        idle();
        repeat (2) @(posedge clk); #1;
        chk("sel0_pkt", pkt_count, 16'd0);
        chk("sel0_err", err_count, 8'd0);
        chk("sel0_state", dbg_state, 1'b0);

        // switch 1->2 mid-packet
        sw = 2'd1;
        flit(1, mk_hdr(14'h2000, 4'd2, 8'd4, 8'd18));
        flit(1, 64'h1111);
        flit(1, 64'h2222);
        sw = 2'd2;
        flit(1, 64'h3333);
        flit(1, 64'h4444);
        finish_pkt("swmid");
        chk("swmid_pkt", pkt_count, 16'd1);
        flit(1, bad_t19);
        idle();
        repeat (2) @(posedge clk); #1;
        chk("swmid_noc1_ignored", err_count, 8'd0);
        flit(2, good0);
        finish_pkt("swmid_noc2");
        chk("swmid_noc2_pkt", pkt_count, 16'd2);

        // payload length boundaries: 8 legal, 9 bad but still drained
        pulse_clear();
        sw = 2'd1;
        flit(1, mk_hdr(14'h2000, 4'd2, 8'd8, 8'd18));
        for (int i = 0; i < 8; i++) flit(1, 64'hAAAA_0000 + 64'(i));
        finish_pkt("len8");
        chk("len8_pkt", pkt_count, 16'd1);
        chk("len8_err", err_count, 8'd0);
        hdr = mk_hdr(14'h2000, 4'd2, 8'd9, 8'd18);
        flit(1, hdr);
        for (int i = 0; i < 8; i++) flit(1, good0);
        idle();
        chk("len9_busy", dbg_state, 1'b1);
        flit(1, 64'hBBBB);
        finish_pkt("len9");
        chk("len9_err", err_count, 8'd1);
        chk("len9_last", last_err_hdr, hdr);
        chk("len9_pkt", pkt_count, 16'd1);

        // err_count saturation
        for (int i = 0; i < 300; i++) flit(1, bad_cid);
        idle();
        repeat (3) @(posedge clk); #1;
        chk("sat_err", err_count, 8'hFF);
        chk("sat_sticky", err_sticky, 1'b1);

        pulse_clear();
        #1;
        chk("clr_pkt", pkt_count, 16'd0);
        chk("clr_err", err_count, 8'd0);
        chk("clr_sticky", err_sticky, 1'b0);

        // clear coincident with a finish
        flit(1, good0);
        finish_pkt("pre_coinc");
        chk("pre_coinc_pkt", pkt_count, 16'd1);
        flit(1, good0);
        @(negedge clk);
        v1 = 1'b0; clear = 1'b1;
        @(posedge clk); #1;
        chk("coinc_done", pkt_done, 1'b1);
        chk("coinc_pkt", pkt_count, 16'd0);
        @(negedge clk);
        clear = 1'b0;

        // reset mid-body
        flit(1, mk_hdr(14'h2000, 4'd2, 8'd4, 8'd18));
        flit(1, 64'h5555);
        flit(1, 64'h6666);
        @(negedge clk);
        v1 = 1'b0; rst_n = 1'b0;
        #1;
        chk("midrst_rdy", r1, 1'b0);
        chk("midrst_state", dbg_state, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        flit(1, good0);
        finish_pkt("post_rst");
        chk("post_rst_pkt", pkt_count, 16'd1);
        chk("post_rst_err", err_count, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
